// File: rtl/ahci_slot_sched.sv
// Multi-slot AHCI command issue scheduler: round-robin slot selection from PxCI,
// header fetch / CFIS transmit sequencing, NCQ outstanding tracking and PxCI clears.
module ahci_slot_sched #(
    parameter int NUM_SLOTS = 32,
    parameter int SLOT_BITS = 5
) (
    input  logic                 mclk,
    input  logic                 hba_rst,
    input  logic                 pcmd_st,
    input  logic [NUM_SLOTS-1:0] pxci,
    input  logic [NUM_SLOTS-1:0] pxsact,
    output logic [NUM_SLOTS-1:0] pxci_clear,
    output logic [SLOT_BITS-1:0] cmd_slot,
    output logic                 fetch_cmd,
    input  logic                 fetch_done,
    output logic                 cfis_xmit,
    input  logic                 xmit_done,
    input  logic                 xmit_err,
    input  logic                 cmd_done,
    input  logic [NUM_SLOTS-1:0] sdb_done,
    output logic [NUM_SLOTS-1:0] issued,
    output logic                 err_pulse,
    output logic                 busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_XMIT,
        ST_WAIT_D2H,
        ST_ERR
    } state_t;

    state_t               state_reg, state_next;
    logic [SLOT_BITS-1:0] cmd_slot_reg, cmd_slot_next;
    logic [SLOT_BITS-1:0] last_slot_reg, last_slot_next;
    logic                 ncq_reg, ncq_next;
    logic [NUM_SLOTS-1:0] issued_reg, issued_next;
    logic [NUM_SLOTS-1:0] pxci_clear_reg, pxci_clear_next;
    logic                 fetch_cmd_reg, fetch_cmd_next;
    logic                 cfis_xmit_reg, cfis_xmit_next;
    logic                 err_pulse_reg, err_pulse_next;

    logic [NUM_SLOTS-1:0] cand;
    logic                 sel_valid;
    logic [SLOT_BITS-1:0] sel_slot;
    logic                 sel_accept;

    // A slot being cleared this cycle still shows in pxci, so it is masked here.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_cand
            assign cand[gi] = pxci[gi] & ~issued_reg[gi] & ~pxci_clear_reg[gi];
        end
    endgenerate

    // Round-robin search starting just after the last fetched slot.
    always_comb begin
        logic [SLOT_BITS-1:0] idx_s;
        sel_valid = 1'b0;
        sel_slot  = '0;
        idx_s     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx_s = SLOT_BITS'((int'(last_slot_reg) + 1 + i) % NUM_SLOTS);
            if (!sel_valid && cand[idx_s]) begin
                sel_valid = 1'b1;
                sel_slot  = idx_s;
            end
        end
    end

    // Non-NCQ commands need the port to themselves; NCQ ones only need no
    // non-NCQ command in flight, which is always true while idle.
    assign sel_accept = sel_valid && (pxsact[sel_slot] || (issued_reg == '0));

    always_comb begin
        state_next      = state_reg;
        cmd_slot_next   = cmd_slot_reg;
        last_slot_next  = last_slot_reg;
        ncq_next        = ncq_reg;
        fetch_cmd_next  = 1'b0;
        cfis_xmit_next  = 1'b0;
        err_pulse_next  = 1'b0;
        pxci_clear_next = sdb_done & issued_reg;
        issued_next     = issued_reg & ~sdb_done;

        if (!pcmd_st) begin
            // Port stopped: software owns PxCI, so drop tracking without clears.
            state_next      = ST_IDLE;
            issued_next     = '0;
            pxci_clear_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sel_accept) begin
                        state_next     = ST_FETCH;
                        fetch_cmd_next = 1'b1;
                        cmd_slot_next  = sel_slot;
                        last_slot_next = sel_slot;
                        ncq_next       = pxsact[sel_slot];
                    end
                end
                ST_FETCH: begin
                    if (fetch_done) begin
                        state_next     = ST_XMIT;
                        cfis_xmit_next = 1'b1;
                    end
                end
                ST_XMIT: begin
                    if (xmit_err) begin
                        state_next     = ST_ERR;
                        err_pulse_next = 1'b1;
                    end else if (xmit_done) begin
                        issued_next[cmd_slot_reg] = 1'b1;
                        state_next = ncq_reg ? ST_IDLE : ST_WAIT_D2H;
                    end
                end
                ST_WAIT_D2H: begin
                    if (cmd_done) begin
                        pxci_clear_next[cmd_slot_reg] = 1'b1;
                        issued_next[cmd_slot_reg]     = 1'b0;
                        state_next                    = ST_IDLE;
                    end
                end
                ST_ERR: begin
                    state_next = ST_ERR;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (hba_rst) begin
            state_reg      <= ST_IDLE;
            cmd_slot_reg   <= '0;
            last_slot_reg  <= SLOT_BITS'(NUM_SLOTS - 1);
            ncq_reg        <= 1'b0;
            issued_reg     <= '0;
            pxci_clear_reg <= '0;
            fetch_cmd_reg  <= 1'b0;
            cfis_xmit_reg  <= 1'b0;
            err_pulse_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cmd_slot_reg   <= cmd_slot_next;
            last_slot_reg  <= last_slot_next;
            ncq_reg        <= ncq_next;
            issued_reg     <= issued_next;
            pxci_clear_reg <= pxci_clear_next;
            fetch_cmd_reg  <= fetch_cmd_next;
            cfis_xmit_reg  <= cfis_xmit_next;
            err_pulse_reg  <= err_pulse_next;
        end
    end

    assign pxci_clear = pxci_clear_reg;
    assign cmd_slot   = cmd_slot_reg;
    assign fetch_cmd  = fetch_cmd_reg;
    assign cfis_xmit  = cfis_xmit_reg;
    assign issued     = issued_reg;
    assign err_pulse  = err_pulse_reg;
    assign busy       = (state_reg != ST_IDLE) || (issued_reg != '0);

endmodule

// File: tb/tb_ahci_slot_sched.sv
// Directed testbench for ahci_slot_sched: models PxCI clearing in the register
// block and checks slot order, NCQ tracking, mixing rules, error/stop and reset.
module tb_ahci_slot_sched;
    localparam int N  = 32;
    localparam int SB = 5;

    logic          mclk = 1'b0;
    logic          hba_rst, pcmd_st, fetch_done, xmit_done, xmit_err, cmd_done;
    logic [N-1:0]  pxci, pxsact, sdb_done, pxci_clear, issued;
    logic [SB-1:0] cmd_slot;
    logic          fetch_cmd, cfis_xmit, err_pulse, busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit hold_pxci = 1'b0;

    ahci_slot_sched #(.NUM_SLOTS(N), .SLOT_BITS(SB)) dut (
        .mclk(mclk), .hba_rst(hba_rst), .pcmd_st(pcmd_st), .pxci(pxci), .pxsact(pxsact),
        .pxci_clear(pxci_clear), .cmd_slot(cmd_slot), .fetch_cmd(fetch_cmd),
        .fetch_done(fetch_done), .cfis_xmit(cfis_xmit), .xmit_done(xmit_done),
        .xmit_err(xmit_err), .cmd_done(cmd_done), .sdb_done(sdb_done), .issued(issued),
        .err_pulse(err_pulse), .busy(busy)
    );

    always #5 mclk = ~mclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock; the register block model clears PxCI bits one edge after the pulse.
    task automatic tick();
        logic [N-1:0] clr;
        clr = pxci_clear;
        @(posedge mclk);
        #1;
        if (!hold_pxci) pxci = pxci & ~clr;
    endtask

    task automatic wait_fetch(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (fetch_cmd) seen = 1'b1;
        end
        if (seen) $display("fetch slot %0d", cmd_slot);
    endtask

    task automatic pulse_fetch_done();
        fetch_done = 1'b1; tick(); fetch_done = 1'b0;
    endtask

    task automatic pulse_xmit_done();
        xmit_done = 1'b1; tick(); xmit_done = 1'b0;
    endtask

    task automatic pulse_cmd_done();
        cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    endtask

    task automatic do_reset();
        hba_rst = 1'b1; tick(); tick(); hba_rst = 1'b0;
    endtask

    task automatic test_reset();
        hba_rst = 1'b1; pcmd_st = 1'b0; pxci = '0; pxsact = '0; sdb_done = '0;
        fetch_done = 1'b0; xmit_done = 1'b0; xmit_err = 1'b0; cmd_done = 1'b0;
        tick(); tick();
        n_checks++; if (fetch_cmd !== 1'b0 || cfis_xmit !== 1'b0 || err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got %b%b%b want 000", fetch_cmd, cfis_xmit, err_pulse); end
        n_checks++; if (issued !== '0 || pxci_clear !== '0) begin n_fail++; $display("FAIL rst_vectors: got issued=%h clr=%h want 0", issued, pxci_clear); end
        n_checks++; if (cmd_slot !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_slot_busy: got slot=%0d busy=%b want 0/0", cmd_slot, busy); end
        hba_rst = 1'b0;
        pxci = 32'h1;
        tick(); tick(); tick();
        n_checks++; if (fetch_cmd !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stopped_no_fetch: got fetch=%b busy=%b want 0/0", fetch_cmd, busy); end
        pxci = '0;
        tick();
    endtask

    task automatic test_non_ncq();
        pcmd_st = 1'b1; pxsact = '0; pxci = 32'h0000_0004;
        tick();
        n_checks++; if (fetch_cmd !== 1'b1) begin n_fail++; $display("FAIL nn_fetch_latency: got %b want 1", fetch_cmd); end
        n_checks++; if (cmd_slot !== 5'd2) begin n_fail++; $display("FAIL nn_slot: got %0d want 2", cmd_slot); end
        tick();
        n_checks++; if (fetch_cmd !== 1'b0) begin n_fail++; $display("FAIL nn_fetch_pulse: got %b want 0", fetch_cmd); end
        pulse_fetch_done();
        n_checks++; if (cfis_xmit !== 1'b1) begin n_fail++; $display("FAIL nn_cfis_xmit: got %b want 1", cfis_xmit); end
        pulse_xmit_done();
        n_checks++; if (issued !== 32'h4 || busy !== 1'b1) begin n_fail++; $display("FAIL nn_issued: got %h busy=%b want 4/1", issued, busy); end
        tick(); tick();
        pulse_cmd_done();
        n_checks++; if (pxci_clear !== 32'h4) begin n_fail++; $display("FAIL nn_clear: got %h want 4", pxci_clear); end
        n_checks++; if (issued !== '0) begin n_fail++; $display("FAIL nn_issued_clr: got %h want 0", issued); end
        tick();
        n_checks++; if (fetch_cmd !== 1'b0 || pxci_clear !== '0) begin n_fail++; $display("FAIL nn_no_reselect: got fetch=%b clr=%h want 0/0", fetch_cmd, pxci_clear); end
        tick();
        n_checks++; if (busy !== 1'b0 || pxci !== '0) begin n_fail++; $display("FAIL nn_idle: got busy=%b pxci=%h want 0/0", busy, pxci); end
    endtask

    task automatic test_round_robin();
        int exp_rr[4];
        bit seen;
        exp_rr = '{0, 1, 31, 0};
        do_reset();
        hold_pxci = 1'b1; pxsact = '0; pxci = 32'h8000_0003;
        for (int k = 0; k < 4; k++) begin
            wait_fetch(8, seen);
            n_checks++; if (!seen) begin n_fail++; $display("FAIL rr_fetch_timeout[%0d]: got none want slot %0d", k, exp_rr[k]); end
            n_checks++; if (int'(cmd_slot) != exp_rr[k]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, cmd_slot, exp_rr[k]); end
            pulse_fetch_done();
            pulse_xmit_done();
            pulse_cmd_done();
            if (k == 3) pxci = '0;
            n_checks++; if (pxci_clear !== (32'h1 << exp_rr[k])) begin n_fail++; $display("FAIL rr_clear[%0d]: got %h want %h", k, pxci_clear, 32'h1 << exp_rr[k]); end
        end
        hold_pxci = 1'b0;
        tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_ncq_back_to_back();
        int quiet;
        bit seen;
        do_reset();
        pxsact = 32'h0F; pxci = 32'h0F;
        for (int k = 0; k < 4; k++) begin
            wait_fetch(4, seen);
            n_checks++; if (!seen || int'(cmd_slot) != k) begin n_fail++; $display("FAIL ncq_order[%0d]: got seen=%b slot=%0d want slot %0d", k, seen, cmd_slot, k); end
            pulse_fetch_done();
            pulse_xmit_done();
        end
        n_checks++; if (issued !== 32'h0F) begin n_fail++; $display("FAIL ncq_issued: got %h want 0f", issued); end
        quiet = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (fetch_cmd) quiet++; end
        n_checks++; if (quiet != 0 || issued !== 32'h0F) begin n_fail++; $display("FAIL ncq_hold: got fetches=%0d issued=%h want 0/0f", quiet, issued); end
        sdb_done = 32'h0A; tick(); sdb_done = '0;
        n_checks++; if (pxci_clear !== 32'h0A) begin n_fail++; $display("FAIL ncq_sdb_clear: got %h want 0a", pxci_clear); end
        n_checks++; if (issued !== 32'h05) begin n_fail++; $display("FAIL ncq_sdb_issued: got %h want 05", issued); end
        tick();
        n_checks++; if (pxci_clear !== '0 || fetch_cmd !== 1'b0) begin n_fail++; $display("FAIL ncq_clear_pulse: got clr=%h fetch=%b want 0/0", pxci_clear, fetch_cmd); end
    endtask

    task automatic test_mixing();
        int stalled;
        sdb_done = 32'h04; tick(); sdb_done = '0;
        tick();
        n_checks++; if (issued !== 32'h01 || pxci !== 32'h01) begin n_fail++; $display("FAIL mix_setup: got issued=%h pxci=%h want 01/01", issued, pxci); end
        pxci = pxci | 32'h20;
        stalled = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (fetch_cmd) stalled++; end
        n_checks++; if (stalled != 0) begin n_fail++; $display("FAIL mix_blocked: got %0d fetches want 0", stalled); end
        sdb_done = 32'h01; tick(); sdb_done = '0;
        n_checks++; if (pxci_clear !== 32'h01 || issued !== '0) begin n_fail++; $display("FAIL mix_sdb: got clr=%h issued=%h want 01/0", pxci_clear, issued); end
        tick();
        n_checks++; if (fetch_cmd !== 1'b1 || cmd_slot !== 5'd5) begin n_fail++; $display("FAIL mix_fetch5: got fetch=%b slot=%0d want 1/5", fetch_cmd, cmd_slot); end
        pulse_fetch_done();
        pulse_xmit_done();
        pulse_cmd_done();
        n_checks++; if (pxci_clear !== 32'h20 || issued !== '0) begin n_fail++; $display("FAIL mix_done: got clr=%h issued=%h want 20/0", pxci_clear, issued); end
        tick();
    endtask

    task automatic test_err_stop();
        int extra;
        bit seen;
        pxsact = 32'h09; pxci = 32'h09;
        wait_fetch(4, seen);
        n_checks++; if (!seen || cmd_slot !== 5'd0) begin n_fail++; $display("FAIL err_first: got seen=%b slot=%0d want slot 0", seen, cmd_slot); end
        pulse_fetch_done();
        pulse_xmit_done();
        wait_fetch(4, seen);
        n_checks++; if (!seen || cmd_slot !== 5'd3) begin n_fail++; $display("FAIL err_second: got seen=%b slot=%0d want slot 3", seen, cmd_slot); end
        pulse_fetch_done();
        xmit_err = 1'b1; tick(); xmit_err = 1'b0;
        n_checks++; if (err_pulse !== 1'b1 || issued !== 32'h01) begin n_fail++; $display("FAIL err_pulse: got pulse=%b issued=%h want 1/01", err_pulse, issued); end
        extra = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (fetch_cmd || err_pulse) extra++; end
        n_checks++; if (extra != 0 || busy !== 1'b1) begin n_fail++; $display("FAIL err_hold: got events=%0d busy=%b want 0/1", extra, busy); end
        pcmd_st = 1'b0; sdb_done = 32'h01; tick(); sdb_done = '0;
        n_checks++; if (issued !== '0 || pxci_clear !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_stop: got issued=%h clr=%h busy=%b want 0/0/0", issued, pxci_clear, busy); end
        pxci = '0; pxsact = '0;
        tick();
        pcmd_st = 1'b1;
        tick();
    endtask

    task automatic test_simultaneous();
        bit seen;
        pxsact = '0; pxci = 32'h10;
        wait_fetch(4, seen);
        n_checks++; if (!seen || cmd_slot !== 5'd4) begin n_fail++; $display("FAIL sim_fetch4: got seen=%b slot=%0d want slot 4", seen, cmd_slot); end
        pulse_fetch_done();
        pulse_xmit_done();
        cmd_done = 1'b1; sdb_done = 32'h11; tick(); cmd_done = 1'b0; sdb_done = '0;
        n_checks++; if (pxci_clear !== 32'h10 || issued !== '0) begin n_fail++; $display("FAIL sim_or_clear: got clr=%h issued=%h want 10/0", pxci_clear, issued); end
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        bit seen;
        pxsact = 32'h06; pxci = 32'h06;
        wait_fetch(4, seen);
        n_checks++; if (!seen || cmd_slot !== 5'd1) begin n_fail++; $display("FAIL rmf_fetch1: got seen=%b slot=%0d want slot 1", seen, cmd_slot); end
        pulse_fetch_done();
        pulse_xmit_done();
        wait_fetch(4, seen);
        n_checks++; if (!seen || cmd_slot !== 5'd2 || issued !== 32'h02) begin n_fail++; $display("FAIL rmf_fetch2: got slot=%0d issued=%h want 2/02", cmd_slot, issued); end
        hba_rst = 1'b1; tick(); hba_rst = 1'b0;
        n_checks++; if (fetch_cmd !== 1'b0 || cfis_xmit !== 1'b0 || err_pulse !== 1'b0 || cmd_slot !== '0) begin n_fail++; $display("FAIL rmf_pulses: got fetch=%b cfis=%b err=%b slot=%0d want 0", fetch_cmd, cfis_xmit, err_pulse, cmd_slot); end
        n_checks++; if (issued !== '0 || pxci_clear !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmf_state: got issued=%h clr=%h busy=%b want 0", issued, pxci_clear, busy); end
        wait_fetch(4, seen);
        n_checks++; if (!seen || cmd_slot !== 5'd1) begin n_fail++; $display("FAIL rmf_restart: got seen=%b slot=%0d want slot 1", seen, cmd_slot); end
    endtask

    initial begin
        test_reset();
        test_non_ncq();
        test_round_robin();
        test_ncq_back_to_back();
        test_mixing();
        test_err_stop();
        test_simultaneous();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
